writeback_unit: RTL

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit_pkg.sv | 22 ++
 rtl/writeback_unit_load_extend.sv | 27 ++
 rtl/writeback_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the writeback unit: load width encodings, FSM states
// and the captured context of an outstanding load.
package writeback_unit_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } wb_state_e;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] offset;
    } ld_ctx_t;

endpackage

// File: rtl/writeback_unit_load_extend.sv
// Combinational load data alignment and sign/zero extension.
module load_extend
    import writeback_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[{offset, 3'b000} +: 8];
        w_half = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            LB:      value = {{24{w_byte[7]}}, w_byte};
            LH:      value = {{16{w_half[15]}}, w_half};
            LBU:     value = {24'd0, w_byte};
            LHU:     value = {16'd0, w_half};
            LW:      value = word;
            default: value = word;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Retire stage writeback: direct ALU results, or waits for one outstanding
// load response, with sticky error on timeout or unsolicited responses.
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_result,
    input  logic        ex_is_load,
    input  logic [2:0]  ex_funct3,
    input  logic [1:0]  ex_addr_lo,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        load_pending,
    output logic [4:0]  pending_rd,
    output logic        err
);

    localparam int CW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    wb_state_e     r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    ld_ctx_t       r_ld, w_ld_nxt;
    logic          r_err, w_err_nxt;
    logic          r_rf_we, w_rf_we_nxt;
    logic [4:0]    r_rf_wa, w_rf_wa_nxt;
    logic [31:0]   r_rf_wd, w_rf_wd_nxt;
    logic          w_accept;
    logic [31:0]   w_ext;

    load_extend u_load_extend (
        .word   (dmem_rdata),
        .funct3 (r_ld.funct3),
        .offset (r_ld.offset),
        .value  (w_ext)
    );

    assign ex_ready     = (r_state == IDLE) && !r_err;
    assign w_accept     = ex_valid && ex_ready;
    assign load_pending = (r_state == WAIT_LOAD);
    assign pending_rd   = (r_state == WAIT_LOAD) ? r_ld.rd : 5'd0;
    assign err          = r_err;
    assign rf_we        = r_rf_we;
    assign rf_wa        = r_rf_wa;
    assign rf_wd        = r_rf_wd;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ld_nxt    = r_ld;
        w_err_nxt   = r_err;
        w_rf_we_nxt = 1'b0;
        w_rf_wa_nxt = r_rf_wa;
        w_rf_wd_nxt = r_rf_wd;
        case (r_state)
            IDLE: begin
                // No load is outstanding, so any response here is unsolicited.
                if (dmem_rvalid) w_err_nxt = 1'b1;
                if (w_accept) begin
                    if (ex_is_load) begin
                        w_ld_nxt    = '{rd: ex_rd, funct3: ex_funct3, offset: ex_addr_lo};
                        w_cnt_nxt   = '0;
                        w_state_nxt = WAIT_LOAD;
                    end else begin
                        w_rf_we_nxt = (ex_rd != 5'd0);
                        w_rf_wa_nxt = ex_rd;
                        w_rf_wd_nxt = ex_result;
                    end
                end
            end
            WAIT_LOAD: begin
                if (dmem_rvalid) begin
                    w_rf_we_nxt = (r_ld.rd != 5'd0);
                    w_rf_wa_nxt = r_ld.rd;
                    w_rf_wd_nxt = w_ext;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    // r_cnt counts completed wait cycles; this is the last allowed one.
                    w_err_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_ld    <= '0;
            r_err   <= 1'b0;
            r_rf_we <= 1'b0;
            r_rf_wa <= 5'd0;
            r_rf_wd <= 32'd0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_ld    <= w_ld_nxt;
            r_err   <= w_err_nxt;
            r_rf_we <= w_rf_we_nxt;
            r_rf_wa <= w_rf_wa_nxt;
            r_rf_wd <= w_rf_wd_nxt;
        end
    end

endmodule
